// File: rtl/axi4s_long_divider.sv
// axi4s_long_divider: AXI4-S responder computing (dividend << Q_BITS_P) / divisor by restoring division.
// Define AXI4S_LONG_DIVIDER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module axi4s_long_divider #(
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int AXI_ID_WIDTH_P   = 4,
  parameter int N_BITS_P         = 32,
  parameter int Q_BITS_P         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ing_tvalid,
  output logic                        ing_tready,
  input  logic [AXI_DATA_WIDTH_P-1:0] ing_tdata,
  input  logic                        ing_tlast,
  input  logic [AXI_ID_WIDTH_P-1:0]   ing_tid,
  output logic                        egr_tvalid,
  input  logic                        egr_tready,
  output logic [AXI_DATA_WIDTH_P-1:0] egr_tdata,
  output logic                        egr_tlast,
  output logic [AXI_ID_WIDTH_P-1:0]   egr_tid,
  output logic                        egr_tuser
);
  localparam int W_C  = N_BITS_P + Q_BITS_P;
  localparam int CW_C = $clog2(W_C + 1);
  typedef enum logic [1:0] {IDLE_E, WAIT_DIVISOR_E, DIVIDE_E, OUTPUT_E} state_t;
  state_t                      r_state;
  logic [N_BITS_P-1:0]         r_dividend, r_den, r_rem;
  logic [W_C-1:0]              r_num;
  logic [CW_C-1:0]             r_cnt;
  logic                        r_sign;
  logic                        r_tvalid, r_tlast, r_tuser;
  logic [AXI_DATA_WIDTH_P-1:0] r_tdata;
  logic [AXI_ID_WIDTH_P-1:0]   r_tid;
  logic [N_BITS_P-1:0]         w_op, w_dvd_mag, w_dvs_mag, w_sat;
  logic [N_BITS_P:0]           w_rem_sh;
  logic [W_C-1:0]              w_quo_nx;
  logic                        w_hs, w_ge, w_sign, w_ovf;
  logic [AXI_DATA_WIDTH_P-1:0] w_res, w_dz;
  assign w_op       = ing_tdata[N_BITS_P-1:0];
  assign ing_tready = (r_state == IDLE_E) || (r_state == WAIT_DIVISOR_E);
  assign w_hs       = ing_tvalid && ing_tready;
  // r_num shifts the dividend out of its MSB while quotient bits enter at the LSB
  assign w_rem_sh   = {r_rem, r_num[W_C-1]};
  assign w_ge       = w_rem_sh >= {1'b0, r_den};
  assign w_quo_nx   = {r_num[W_C-2:0], w_ge};
`ifdef AXI4S_LONG_DIVIDER_SIGNED_EN
  localparam logic [N_BITS_P-1:0] MAX_C = {1'b0, {(N_BITS_P-1){1'b1}}};
  localparam logic [N_BITS_P-1:0] MIN_C = ~MAX_C;
  assign w_dvd_mag = r_dividend[N_BITS_P-1] ? -r_dividend : r_dividend;
  assign w_dvs_mag = w_op[N_BITS_P-1] ? -w_op : w_op;
  assign w_sign    = r_dividend[N_BITS_P-1] ^ w_op[N_BITS_P-1];
  assign w_ovf     = w_quo_nx > (r_sign ? W_C'(MIN_C) : W_C'(MAX_C));
  assign w_sat     = w_ovf ? (r_sign ? MIN_C : MAX_C) :
                     (r_sign ? -w_quo_nx[N_BITS_P-1:0] : w_quo_nx[N_BITS_P-1:0]);
  assign w_res     = AXI_DATA_WIDTH_P'($signed(w_sat));
  assign w_dz      = AXI_DATA_WIDTH_P'($signed(r_dividend[N_BITS_P-1] ? MIN_C : MAX_C));
  wire w_unused = &{1'b0, ing_tdata};
`else
  localparam logic [N_BITS_P-1:0] MAX_C = '1;
  assign w_dvd_mag = r_dividend;
  assign w_dvs_mag = w_op;
  assign w_sign    = 1'b0;
  assign w_ovf     = w_quo_nx > W_C'(MAX_C);
  assign w_sat     = w_ovf ? MAX_C : w_quo_nx[N_BITS_P-1:0];
  assign w_res     = AXI_DATA_WIDTH_P'(w_sat);
  assign w_dz      = AXI_DATA_WIDTH_P'(MAX_C);
  wire w_unused = &{1'b0, ing_tdata, r_sign};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE_E;
      r_dividend <= '0;
      r_den      <= '0;
      r_rem      <= '0;
      r_num      <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_tdata    <= '0;
      r_tid      <= '0;
    end else
      case (r_state)
        IDLE_E:
          if (w_hs && !ing_tlast) begin
            r_dividend <= w_op;
            r_state    <= WAIT_DIVISOR_E;
          end
        WAIT_DIVISOR_E:
          if (w_hs && !ing_tlast) r_dividend <= w_op;
          else if (w_hs) begin
            r_tid <= ing_tid;
            r_den <= w_dvs_mag;
            if (w_op == '0) begin
              r_tdata  <= w_dz;
              r_tuser  <= 1'b1;
              r_tvalid <= 1'b1;
              r_tlast  <= 1'b1;
              r_state  <= OUTPUT_E;
            end else begin
              r_num   <= W_C'(w_dvd_mag) << Q_BITS_P;
              r_rem   <= '0;
              r_cnt   <= CW_C'(W_C);
              r_sign  <= w_sign;
              r_state <= DIVIDE_E;
            end
          end
        DIVIDE_E: begin
          r_rem <= w_ge ? N_BITS_P'(w_rem_sh - {1'b0, r_den}) : w_rem_sh[N_BITS_P-1:0];
          r_num <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW_C'(1)) begin
            r_tdata  <= w_res;
            r_tuser  <= w_ovf;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_state  <= OUTPUT_E;
          end
        end
        default:
          if (egr_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= IDLE_E;
          end
      endcase
  assign egr_tvalid = r_tvalid;
  assign egr_tdata  = r_tdata;
  assign egr_tlast  = r_tlast;
  assign egr_tid    = r_tid;
  assign egr_tuser  = r_tuser;
endmodule

// File: doc/axi4s_long_divider.md
# axi4s_long_divider

- Fixed-point long-division responder on the AXI4-S divider port pair used by the coefficient-calculation blocks (for example, f0/fs for w0, and sin(w0)/2Q for alfa).
- Accepts a two-beat request: dividend, then divisor with tlast.
- Computes quotient = (dividend << Q_BITS_P) / divisor by iterative restoring division, one bit per cycle.
- Returns one result beat carrying the requester's tid and an overflow flag in tuser.

## Interface
- AXI_DATA_WIDTH_P, -1: tdata width; must be >= N_BITS_P.
- AXI_ID_WIDTH_P, -1: tid width.
- N_BITS_P, -1: operand and quotient width.
- Q_BITS_P, -1: fractional bits of the quotient.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ing_tvalid  in  1  request beat valid.
- ing_tready  out  1  request beat accepted.
- ing_tdata  in  AXI_DATA_WIDTH_P  operand in bits [N_BITS_P-1:0]; upper bits ignored.
- ing_tlast  in  1  0 = dividend beat, 1 = divisor beat.
- ing_tid  in  AXI_ID_WIDTH_P  requester id.
- egr_tvalid  out  1  result valid.
- egr_tready  in  1  result accepted.
- egr_tdata  out  AXI_DATA_WIDTH_P  quotient, sign-extended (signed build) or zero-extended.
- egr_tlast  out  1  always 1 when egr_tvalid is 1.
- egr_tid  out  AXI_ID_WIDTH_P  tid latched from the divisor beat.
- egr_tuser  out  1  overflow or divide-by-zero.

## Operation
- States: IDLE_E, WAIT_DIVISOR_E, DIVIDE_E, OUTPUT_E.
- ing_tready = 1 in IDLE_E and WAIT_DIVISOR_E, 0 otherwise (decoded from the state register).
- **IDLE_E**
  - A handshake with tlast=0 latches the dividend and moves to WAIT_DIVISOR_E.
  - A handshake with tlast=1 is accepted and discarded; the state stays IDLE_E.
- **WAIT_DIVISOR_E**
  - A handshake with tlast=0 replaces the dividend; the state stays.
  - A handshake with tlast=1 latches the divisor and tid.
  - Divisor == 0: go to OUTPUT_E with the saturated result and tuser=1.
  - Otherwise: load |dividend| << Q_BITS_P and |divisor|, set the counter to N_BITS_P+Q_BITS_P, record sign = sign(dividend) XOR sign(divisor), and go to DIVIDE_E.
- **DIVIDE_E**
  - Each cycle: shift the remainder left by 1 and bring in the next dividend MSB.
  - If remainder >= divisor, subtract the divisor and shift 1 into the quotient; otherwise shift 0.
  - Decrement the counter. At counter==1 the last step is done; go to OUTPUT_E.
- **Result** (truncated toward zero; magnitude quotient is N_BITS_P+Q_BITS_P bits):
  - Positive result with magnitude > 2^(N_BITS_P-1)-1: result = max positive, tuser=1.
  - Negative result with magnitude > 2^(N_BITS_P-1): result = min negative, tuser=1.
  - Otherwise: the negated or plain magnitude, tuser=0.
- **Divide by zero:** result = max positive if dividend >= 0, min negative if dividend < 0; tuser=1.
- **OUTPUT_E**
  - egr_tvalid=1 with egr_tdata, egr_tid, egr_tuser and egr_tlast=1 held stable until egr_tready.
  - On handshake, egr_tvalid drops and the state returns to IDLE_E.
- Reset mid-operation aborts any division; no partial result is emitted.
- Reset values: ing_tready=1, egr_tvalid=0, egr_tdata=0, egr_tlast=0, egr_tid=0, egr_tuser=0, state IDLE_E.

## Timing
- Divisor handshake at cycle T, divisor != 0: egr_tvalid first high at T+N_BITS_P+Q_BITS_P+1.
- Divisor handshake at cycle T, divisor == 0: egr_tvalid first high at T+1.
- egr_tvalid falls the cycle after the egr handshake.
- ing_tready rises in the same cycle egr_tvalid falls.
- One request in flight at a time; no request is accepted while DIVIDE_E or OUTPUT_E is active.
- egr_tready held 0 indefinitely stalls the block in OUTPUT_E with outputs unchanged.

## Configuration
- AXI4S_LONG_DIVIDER_SIGNED_EN defined:
  - Operands are two's complement, with the sign handling above.
  - egr_tdata is sign-extended.
- Undefined:
  - Operands and quotient are unsigned; sign logic is removed.
  - Overflow means quotient > 2^N_BITS_P-1; saturation value 2^N_BITS_P-1.
  - Divide-by-zero returns 2^N_BITS_P-1 with tuser=1.
  - egr_tdata is zero-extended.

## Test plan
All scenarios use N_BITS_P=32, Q_BITS_P=16, signed build unless stated.
- Dividend 1000, divisor 48000, tid 3 -> egr_tdata 0x00000555, tuser 0, tid 3, tlast 1, valid at T+49.
- Dividend -3, divisor 2 -> 0xFFFE8000, tuser 0. Dividend 3, divisor -2 -> 0xFFFE8000.
- Dividend 0x7FFFFFFF, divisor 1 -> 0x7FFFFFFF, tuser 1. Dividend -32768, divisor 1 -> 0x80000000, tuser 0.
- Dividend -5, divisor 0 -> 0x80000000, tuser 1, valid at T+1.
- Protocol robustness:
  - tlast=1 beat in IDLE_E is discarded.
  - Two dividend beats 7 then 10, followed by divisor 5 -> 0x00020000.
  - egr_tready low for 20 cycles -> outputs stable and ing_tready 0 throughout.
  - rst_n asserted mid-DIVIDE_E -> no egr_tvalid, ing_tready 1.
- Unsigned build: dividend 0xFFFFFFFF, divisor 0x00020000 -> 0x7FFFFFFF, tuser 0.
